// File: rtl/wish_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter.
// Contents: arbiter state encoding, a constant clog2 helper, and default widths.
package wish_arb_pkg;

  localparam int unsigned DEF_NUM_MASTERS    = 2;
  localparam int unsigned DEF_DATA_WIDTH     = 64;
  localparam int unsigned DEF_TGC_WIDTH      = 2;
  localparam int unsigned DEF_MAX_BURST      = 0;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Ceiling log2, usable in constant expressions; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/wish_rr_pick.sv
// Combinational round-robin picker: returns the first requester found when
// scanning upward from last_i+1, wrapping modulo NUM_MASTERS.
// Ports:
//   req_i   - request vector, one bit per master
//   last_i  - index of the most recent grant (scan starts just above it)
//   gnt_o   - one-hot winner (all zero when nobody requests)
//   idx_o   - winner index
//   valid_o - at least one request present
module wish_rr_pick
  import wish_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned IDX_W       = clog2(DEF_NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   valid_o
);

  int unsigned cand;

  // Scan offsets 1..NUM_MASTERS so the previous winner is considered last.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = 32'(last_i) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!valid_o && req_i[IDX_W'(cand)]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/wish_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style stream sink between
// NUM_MASTERS sources. A grant is held while the owner keeps cyc asserted;
// MAX_BURST (nonzero) forces rotation after that many accepted acks.
// Every release costs one IDLE cycle before the next grant.
// Optional feature: define WISH_ARB_TIMEOUT_EN to enable a stall watchdog that
// pulses err_o and releases an owner stalled for TIMEOUT_CYCLES cycles.
// Ports:
//   clk_i, rst_n_i      - clock, asynchronous active-low reset
//   m_dat_i/m_tgc_i     - per-master data/tag, master k at slice k*W +: W
//   m_stb_i/m_cyc_i     - per-master strobe / cycle request
//   m_ack_o             - per-master ack (owner only, mirrors s_ack_i)
//   s_dat_o..s_tgc_o    - owner's bus routed to the sink (zero when idle)
//   s_ack_i             - sink ack
//   gnt_o               - registered one-hot grant
//   err_o               - one-cycle watchdog pulse (0 without the feature)
module wish_rr_arbiter
  import wish_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = DEF_NUM_MASTERS,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned TGC_WIDTH      = DEF_TGC_WIDTH,
  parameter int unsigned MAX_BURST      = DEF_MAX_BURST,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS*TGC_WIDTH-1:0] m_tgc_i,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [DATA_WIDTH-1:0]           s_dat_o,
  output logic                            s_stb_o,
  output logic                            s_cyc_o,
  output logic [TGC_WIDTH-1:0]            s_tgc_o,
  input  logic                            s_ack_i,
  output logic [NUM_MASTERS-1:0]          gnt_o,
  output logic                            err_o
);

  localparam int unsigned IDX_W   = (clog2(NUM_MASTERS) < 1) ? 1 : clog2(NUM_MASTERS);
  localparam int unsigned BURST_W = (MAX_BURST == 0) ? 1 : clog2(MAX_BURST + 1);

  // Reject configurations the arbiter cannot honour.
  if (NUM_MASTERS < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("wish_rr_arbiter: NUM_MASTERS must be >= 2 and TIMEOUT_CYCLES nonzero");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [BURST_W-1:0]     burst_q, burst_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic                   own_cyc, own_stb;
  logic [DATA_WIDTH-1:0]  own_dat;
  logic [TGC_WIDTH-1:0]   own_tgc;
  logic                   owned_c, accept_c, limit_c, timeout_c, release_c;

  wish_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req_i   (m_cyc_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // While OWNED, last_q is the owner's index.
  assign own_cyc = m_cyc_i[last_q];
  assign own_stb = m_stb_i[last_q];
  assign own_dat = m_dat_i[32'(last_q)*DATA_WIDTH +: DATA_WIDTH];
  assign own_tgc = m_tgc_i[32'(last_q)*TGC_WIDTH +: TGC_WIDTH];

  assign owned_c  = (state_q == ST_OWNED);
  assign accept_c = owned_c && own_stb && s_ack_i;
  // The ack that completes the MAX_BURST-th transfer ends the tenure.
  assign limit_c  = (MAX_BURST != 0) && accept_c &&
                    (burst_q == BURST_W'(MAX_BURST - 1));
  assign release_c = owned_c && (!own_cyc || limit_c || timeout_c);

`ifdef WISH_ARB_TIMEOUT_EN
  localparam int unsigned STALL_W = (clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 :
                                    clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               err_q;

  // Counts cycles the owner strobes without an ack; cleared by ack or leaving OWNED.
  always_comb begin
    stall_d = stall_q;
    if (!owned_c || s_ack_i) begin
      stall_d = '0;
    end else if (own_stb && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  assign timeout_c = owned_c && own_stb && !s_ack_i &&
                     (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= timeout_c;
    end
  end

  assign err_o = err_q;
`else
  assign timeout_c = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Next-state logic and owner routing.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    burst_d = burst_q;
    s_dat_o = '0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    s_tgc_o = '0;
    m_ack_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWNED;
          gnt_d   = pick_gnt;
          last_d  = pick_idx;
          burst_d = '0;
        end
      end
      ST_OWNED: begin
        s_dat_o         = own_dat;
        s_stb_o         = own_stb;
        s_cyc_o         = own_cyc;
        s_tgc_o         = own_tgc;
        m_ack_o[last_q] = s_ack_i;
        if (accept_c && (burst_q != '1)) burst_d = burst_q + BURST_W'(1);
        if (release_c) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wish_rr_arbiter.sv
// Self-checking bench for wish_rr_arbiter. Two instances share the stimulus:
// u_dut (MAX_BURST=0) and u_dut_b (MAX_BURST=4), both TIMEOUT_CYCLES=8.
// A transaction-level model (owner index, last winner, ack and stall counts)
// predicts every output each cycle. Honours WISH_ARB_TIMEOUT_EN like the RTL.
module tb_wish_rr_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int TW = 2;
  localparam int TO = 8;
  localparam int MB = 4;
  localparam int OW = 2*N + TW + 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [N*DW-1:0] m_dat;
  logic [N-1:0]    m_stb, m_cyc;
  logic [N*TW-1:0] m_tgc;
  logic            s_ack;

  logic [N-1:0]  a_ack, a_gnt, b_ack, b_gnt;
  logic [DW-1:0] a_dat, b_dat;
  logic          a_stb, a_cyc, a_err, b_stb, b_cyc, b_err;
  logic [TW-1:0] a_tgc, b_tgc;

  int checks = 0;
  int errors = 0;

  // Model state per instance: owner (-1 = none), last winner, acks this tenure.
  int   own[2];
  int   last_m[2];
  int   cnt_m[2];
  int   stall_m[2];
  logic err_m[2];
  int   mb_lim[2];

  always #5 clk = ~clk;

  wish_rr_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .TGC_WIDTH(TW),
                    .MAX_BURST(0), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .m_dat_i(m_dat), .m_stb_i(m_stb),
    .m_cyc_i(m_cyc), .m_tgc_i(m_tgc), .m_ack_o(a_ack), .s_dat_o(a_dat),
    .s_stb_o(a_stb), .s_cyc_o(a_cyc), .s_tgc_o(a_tgc), .s_ack_i(s_ack),
    .gnt_o(a_gnt), .err_o(a_err));

  wish_rr_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .TGC_WIDTH(TW),
                    .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .m_dat_i(m_dat), .m_stb_i(m_stb),
    .m_cyc_i(m_cyc), .m_tgc_i(m_tgc), .m_ack_o(b_ack), .s_dat_o(b_dat),
    .s_stb_o(b_stb), .s_cyc_o(b_cyc), .s_tgc_o(b_tgc), .s_ack_i(s_ack),
    .gnt_o(b_gnt), .err_o(b_err));

  function automatic logic [OW-1:0] obs_vec(input int i);
    if (i == 0) return {a_gnt, a_ack, a_cyc, a_stb, a_tgc, a_err};
    return {b_gnt, b_ack, b_cyc, b_stb, b_tgc, b_err};
  endfunction

  function automatic logic [DW-1:0] obs_dat(input int i);
    return (i == 0) ? a_dat : b_dat;
  endfunction

  function automatic logic [OW-1:0] exp_vec(input int i);
    logic [N-1:0] g, a;
    logic c, s;
    logic [TW-1:0] t;
    g = '0; a = '0; c = 1'b0; s = 1'b0; t = '0;
    if (own[i] >= 0) begin
      g[own[i]] = 1'b1;
      a[own[i]] = s_ack;
      c = m_cyc[own[i]];
      s = m_stb[own[i]];
      t = m_tgc[own[i]*TW +: TW];
    end
    return {g, a, c, s, t, err_m[i]};
  endfunction

  function automatic logic [DW-1:0] exp_dat(input int i);
    return (own[i] >= 0) ? m_dat[own[i]*DW +: DW] : '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      own[i] = -1; last_m[i] = N - 1; cnt_m[i] = 0; stall_m[i] = 0; err_m[i] = 1'b0;
    end
    mb_lim[0] = 0;
    mb_lim[1] = MB;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (own[i] < 0) begin
        err_m[i] = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (last_m[i] + k) % N;
          if (own[i] < 0 && m_cyc[c]) begin
            own[i] = c; last_m[i] = c; cnt_m[i] = 0; stall_m[i] = 0;
          end
        end
      end else begin
        bit acc, rel, to;
        int o;
        o = own[i];
        acc = m_stb[o] && s_ack;
        rel = !m_cyc[o];
        if (mb_lim[i] != 0 && acc && cnt_m[i] + 1 == mb_lim[i]) rel = 1'b1;
        if (acc) cnt_m[i]++;
        to = 1'b0;
`ifdef WISH_ARB_TIMEOUT_EN
        if (s_ack) stall_m[i] = 0;
        else if (m_stb[o]) begin
          if (stall_m[i] + 1 == TO) to = 1'b1;
          stall_m[i]++;
        end
`endif
        err_m[i] = to;
        if (to) rel = 1'b1;
        if (rel) own[i] = -1;
      end
    end
  endtask

  task automatic do_reset();
    m_cyc = '0; m_stb = '0; s_ack = 1'b0; m_tgc = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
    m_dat = {$urandom, $urandom, $urandom, $urandom}; m_tgc = 4'b1001;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_vec(i) !== '0 || obs_dat(i) !== '0) begin
        errors++;
        $display("FAIL reset inst%0d got %h/%h want all zero", i, obs_vec(i), obs_dat(i));
      end
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_two_stream();
    do_reset();
    for (int t = 0; t < 12; t++) begin
      m_cyc = (t >= 6) ? 2'b10 : 2'b11;
      m_stb = 2'b11; s_ack = 1'b1;
      m_dat = {$urandom, $urandom, $urandom, $urandom}; m_tgc = 4'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i) || obs_dat(i) !== exp_dat(i)) begin
          errors++;
          $display("FAIL two_stream inst%0d t%0d got %h/%h want %h/%h", i, t, obs_vec(i), obs_dat(i), exp_vec(i), exp_dat(i));
        end
      end
      if (t >= 1 && t <= 6) begin
        checks++;
        if (a_gnt !== 2'b01) begin errors++; $display("FAIL two_stream_hold t%0d gnt %b want 01", t, a_gnt); end
      end
      if (t == 7) begin
        checks++;
        if (a_gnt !== 2'b00) begin errors++; $display("FAIL two_stream_gap gnt %b want 00", a_gnt); end
      end
      if (t == 8) begin
        checks++;
        if (a_gnt !== 2'b10) begin errors++; $display("FAIL two_stream_next gnt %b want 10", a_gnt); end
      end
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic test_burst();
    int a0, a1, b0, b1;
    a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
      m_dat = {$urandom, $urandom, $urandom, $urandom}; m_tgc = 4'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i) || obs_dat(i) !== exp_dat(i)) begin
          errors++;
          $display("FAIL burst inst%0d t%0d got %h/%h want %h/%h", i, t, obs_vec(i), obs_dat(i), exp_vec(i), exp_dat(i));
        end
      end
      a0 += int'(a_ack[0]); a1 += int'(a_ack[1]);
      b0 += int'(b_ack[0]); b1 += int'(b_ack[1]);
      model_step();
      @(negedge clk);
    end
    // Limited: idle, 4 x m0, idle, 4 x m1 repeating -> 12 each in 30 cycles.
    checks++;
    if (b0 != 12 || b1 != 12) begin errors++; $display("FAIL burst_counts m0=%0d m1=%0d want 12/12", b0, b1); end
    checks++;
    if (a0 != 29 || a1 != 0) begin errors++; $display("FAIL unlimited_counts m0=%0d m1=%0d want 29/0", a0, a1); end
  endtask

  task automatic test_single();
    do_reset();
    for (int t = 0; t < 10; t++) begin
      m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'($urandom);
      m_dat[DW +: DW] = 64'h1234; m_dat[0 +: DW] = {$urandom, $urandom};
      m_tgc = 4'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i) || obs_dat(i) !== exp_dat(i)) begin
          errors++;
          $display("FAIL single inst%0d t%0d got %h/%h want %h/%h", i, t, obs_vec(i), obs_dat(i), exp_vec(i), exp_dat(i));
        end
      end
      if (t >= 1) begin
        checks++;
        if (a_dat !== 64'h1234 || a_ack !== {s_ack, 1'b0}) begin
          errors++;
          $display("FAIL single_route t%0d dat %h ack %b want 1234 %b", t, a_dat, a_ack, {s_ack, 1'b0});
        end
      end
      checks++;
      if (a_ack[0] !== 1'b0) begin errors++; $display("FAIL single_ack0 t%0d ack0 %b want 0", t, a_ack[0]); end
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic test_drop_at_limit();
    do_reset();
    for (int t = 0; t < 9; t++) begin
      m_cyc = (t >= 4) ? 2'b10 : 2'b11;
      m_stb = 2'b11; s_ack = 1'b1;
      m_dat = {$urandom, $urandom, $urandom, $urandom}; m_tgc = 4'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i) || obs_dat(i) !== exp_dat(i)) begin
          errors++;
          $display("FAIL drop_limit inst%0d t%0d got %h/%h want %h/%h", i, t, obs_vec(i), obs_dat(i), exp_vec(i), exp_dat(i));
        end
      end
      if (t == 5) begin
        checks++;
        if (b_gnt !== 2'b00) begin errors++; $display("FAIL drop_limit_gap gnt %b want 00", b_gnt); end
      end
      if (t == 6 || t == 7) begin
        checks++;
        if (b_gnt !== 2'b10 || b_ack !== 2'b10) begin
          errors++;
          $display("FAIL drop_limit_next t%0d gnt %b ack %b want 10 10", t, b_gnt, b_ack);
        end
      end
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    pulses = 0;
    do_reset();
    for (int t = 0; t < 14; t++) begin
      m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b0;
      m_dat = {$urandom, $urandom, $urandom, $urandom}; m_tgc = 4'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i) || obs_dat(i) !== exp_dat(i)) begin
          errors++;
          $display("FAIL timeout inst%0d t%0d got %h/%h want %h/%h", i, t, obs_vec(i), obs_dat(i), exp_vec(i), exp_dat(i));
        end
      end
      pulses += int'(a_err);
`ifdef WISH_ARB_TIMEOUT_EN
      if (t == 10) begin
        checks++;
        if (a_gnt !== 2'b10) begin errors++; $display("FAIL timeout_pass gnt %b want 10", a_gnt); end
      end
`else
      if (t == 13) begin
        checks++;
        if (a_gnt !== 2'b01) begin errors++; $display("FAIL stall_hold gnt %b want 01", a_gnt); end
      end
`endif
      model_step();
      @(negedge clk);
    end
`ifdef WISH_ARB_TIMEOUT_EN
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL timeout_pulses got %0d want 1", pulses); end
`else
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL err_tied got %0d pulses want 0", pulses); end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(7) == 0) m_cyc[k] = ~m_cyc[k];
        m_stb[k] = ($urandom_range(3) != 0);
      end
      s_ack = 1'($urandom);
      m_dat = {$urandom, $urandom, $urandom, $urandom}; m_tgc = 4'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i) || obs_dat(i) !== exp_dat(i)) begin
          errors++;
          $display("FAIL random inst%0d t%0d got %h/%h want %h/%h", i, t, obs_vec(i), obs_dat(i), exp_vec(i), exp_dat(i));
        end
      end
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int t = 0; t < 3; t++) begin
      m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
      m_dat = {$urandom, $urandom, $urandom, $urandom}; m_tgc = 4'($urandom);
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i) || obs_dat(i) !== exp_dat(i)) begin
          errors++;
          $display("FAIL pre_reset inst%0d t%0d got %h/%h want %h/%h", i, t, obs_vec(i), obs_dat(i), exp_vec(i), exp_dat(i));
        end
      end
      model_step();
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_cyc !== 1'b0 || a_gnt !== 2'b00 || b_cyc !== 1'b0 || b_gnt !== 2'b00 || a_ack !== 2'b00) begin
      errors++;
      $display("FAIL async_reset cyc %b/%b gnt %b/%b ack %b want zeros", a_cyc, b_cyc, a_gnt, b_gnt, a_ack);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int t = 0; t < 4; t++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_vec(i) !== exp_vec(i) || obs_dat(i) !== exp_dat(i)) begin
          errors++;
          $display("FAIL post_reset inst%0d t%0d got %h/%h want %h/%h", i, t, obs_vec(i), obs_dat(i), exp_vec(i), exp_dat(i));
        end
      end
      if (t == 1) begin
        checks++;
        if (a_gnt !== 2'b01 || b_gnt !== 2'b01) begin
          errors++;
          $display("FAIL post_reset_first gnt %b/%b want 01", a_gnt, b_gnt);
        end
      end
      model_step();
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_dat = '0; m_stb = '0; m_cyc = '0; m_tgc = '0; s_ack = 1'b0;
    model_reset();
    test_reset();
    test_two_stream();
    test_burst();
    test_single();
    test_drop_at_limit();
    test_timeout();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
